// File: rtl/info_bcd_scheduler.sv
// info_bcd_scheduler: one shared shift-add-3 binary-to-BCD engine serving the
// info panel's score, score_req and timer fields. Changed inputs are converted
// round-robin and the registered BCD results feed the panel's character lookup.
// Optional build macro: BCD_LEADING_BLANK_EN replaces leading zero digits of
// every written result with 4'hF (digit 0 is never blanked).
module info_bcd_scheduler #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 6
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      score,
    input  logic [BIN_W-1:0]      score_req,
    input  logic [11:0]           timer,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   score_req_bcd,
    output logic [4*DIGITS-1:0]   timer_bcd,
    output logic                  busy,
    output logic                  conv_done
);

    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] CLAMP_MAX = BIN_W'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         rr_q;
    logic [1:0]         ch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   snap_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [OUT_W-1:0]   bcd_q;
    logic [OUT_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   last_q [3];
    logic [OUT_W-1:0]   out_q  [3];
    logic               conv_done_q;

    logic [BIN_W-1:0]   in_w   [3];
    logic [2:0]         req;
    logic               any_req;
    logic [1:0]         grant;

    assign in_w[0] = score;
    assign in_w[1] = score_req;
    assign in_w[2] = BIN_W'(timer);

    // Wraps rr_q + offset (at most 5) back into channel range 0..2.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : 2'(v);
    endfunction

`ifdef BCD_LEADING_BLANK_EN
    // Blank zero digits from the MSD down to the first nonzero digit.
    function automatic logic [OUT_W-1:0] fmt_result(input logic [OUT_W-1:0] raw);
        logic [OUT_W-1:0] res;
        logic             lead;
        res  = raw;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (raw[4*d +: 4] == 4'd0)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction
`else
    // Raw digits, leading zeros kept.
    function automatic logic [OUT_W-1:0] fmt_result(input logic [OUT_W-1:0] raw);
        return raw;
    endfunction
`endif

    // Level-sensitive requests and round-robin grant starting after rr_q.
    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        any_req = 1'b0;
        grant   = 2'd0;
        for (int c = 0; c < 3; c++) begin
            req[c] = (in_w[c] != last_q[c]);
        end
        for (int off = 1; off <= 3; off++) begin
            if (!any_req && req[wrap3(3'(rr_q) + 3'(off))]) begin
                any_req = 1'b1;
                grant   = wrap3(3'(rr_q) + 3'(off));
            end
        end
    end

    // Add-3 correction of every BCD digit that is 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT on a grant, BIN_W shifts, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_SHIFT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Engine datapath, arbitration pointer and result registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rr_q        <= 2'd2;
            ch_q        <= 2'd0;
            cnt_q       <= '0;
            snap_q      <= '0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            conv_done_q <= 1'b0;
            // NOTE: the result and last-value arrays are a handful of flops feeding live logic, so they are reset like any register.
            for (int c = 0; c < 3; c++) begin
                last_q[c] <= '0;
                out_q[c]  <= '0;
            end
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        rr_q    <= grant;
                        ch_q    <= grant;
                        snap_q  <= in_w[grant];
                        shreg_q <= (in_w[grant] > CLAMP_MAX) ? CLAMP_MAX : in_w[grant];
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_q, shreg_q} <= {bcd_adj, shreg_q} << 1;
                    cnt_q            <= cnt_q + 1'b1;
                end
                DONE: begin
                    // last_q keeps the raw value so a clamped input stops requesting.
                    out_q[ch_q]  <= fmt_result(bcd_q);
                    last_q[ch_q] <= snap_q;
                    conv_done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign score_bcd     = out_q[0];
    assign score_req_bcd = out_q[1];
    assign timer_bcd     = out_q[2];
    assign conv_done     = conv_done_q;

endmodule

// File: tb/tb_info_bcd_scheduler.sv
// Self-checking bench for info_bcd_scheduler: directed scenarios plus a
// randomized run, all checked against a cycle-level reference model built on
// integer division for BCD and a simple occupancy counter for the engine.
module tb_info_bcd_scheduler;

    localparam int BIN_W = 24;
    localparam int CONV_EDGES = BIN_W + 1;   // grant edge to result edge

    logic        pclk = 1'b0;
    logic        rst;
    logic [23:0] score, score_req;
    logic [11:0] timer;
    logic [23:0] score_bcd, score_req_bcd, timer_bcd;
    logic        busy, conv_done;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    info_bcd_scheduler dut (
        .pclk          (pclk),
        .rst           (rst),
        .score         (score),
        .score_req     (score_req),
        .timer         (timer),
        .score_bcd     (score_bcd),
        .score_req_bcd (score_req_bcd),
        .timer_bcd     (timer_bcd),
        .busy          (busy),
        .conv_done     (conv_done)
    );

    // Reference model state
    logic [23:0] m_last [3];
    logic [23:0] m_out  [3];
    logic [23:0] m_snap;
    int          m_rr;
    int          m_ch;
    int          m_left;   // engine edges still to go in the current conversion
    bit          m_done;

    function automatic logic [23:0] ref_bcd(input logic [23:0] raw);
        int          v;
        logic [23:0] r;
`ifdef BCD_LEADING_BLANK_EN
        bit          lead;
`endif
        v = (raw > 24'd999999) ? 999999 : int'(raw);
        r = '0;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        lead = 1'b1;
        for (int d = 5; d >= 1; d--) begin
            if (lead && r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    function automatic logic [23:0] in_val(input int ch);
        if (ch == 0) return score;
        if (ch == 1) return score_req;
        return {12'd0, timer};
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_last[k] = '0;
                m_out[k]  = '0;
            end
            m_rr   = 2;
            m_left = 0;
        end else if (m_left == 0) begin
            for (int off = 1; off <= 3; off++) begin
                int c = (m_rr + off) % 3;
                if (m_left == 0 && in_val(c) != m_last[c]) begin
                    m_ch   = c;
                    m_rr   = c;
                    m_snap = in_val(c);
                    m_left = CONV_EDGES;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_out[m_ch]  = ref_bcd(m_snap);
                m_last[m_ch] = m_snap;
                m_done       = 1'b1;
            end
        end
    endtask

    // One clock: the model sees the same inputs as the DUT at the edge; outputs settle by #1.
    task automatic tick();
        @(posedge pclk);
        model_step();
        #1;
    endtask

    task automatic wait_done(input int limit, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            if (conv_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; score = '0; score_req = '0; timer = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || conv_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle: %0d active cycles, required 0", bad); end
        checks++;
        if (score_bcd !== 24'h0) begin errors++; $display("FAIL reset_score: got %h want 000000", score_bcd); end
        checks++;
        if (score_req_bcd !== 24'h0) begin errors++; $display("FAIL reset_score_req: got %h want 000000", score_req_bcd); end
        checks++;
        if (timer_bcd !== 24'h0) begin errors++; $display("FAIL reset_timer: got %h want 000000", timer_bcd); end
    endtask

    task automatic test_single();
        int n = 0;
        int busy_bad = 0;
        int extra = 0;
        bit seen = 1'b0;
        score = 24'd123456;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (conv_done === 1'b1) seen = 1'b1;
            if (busy !== (m_left != 0)) busy_bad++;
        end
        checks++;
        if (!seen || n != 26) begin errors++; $display("FAIL single_latency: done after %0d edges (seen=%0b), want 26", n, seen); end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL single_busy: %0d wrong busy samples, want 0", busy_bad); end
        checks++;
        if (score_bcd !== ref_bcd(24'd123456)) begin errors++; $display("FAIL single_score: got %h want %h", score_bcd, ref_bcd(24'd123456)); end
        checks++;
        if (score_req_bcd !== 24'h0 || timer_bcd !== 24'h0) begin
            errors++; $display("FAIL single_others: got %h/%h want 000000/000000", score_req_bcd, timer_bcd);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (conv_done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL single_once: %0d extra active cycles, want 0", extra); end
    endtask

    task automatic test_order();
        logic [23:0] exp_s  [3];
        logic [23:0] exp_r  [3];
        logic [23:0] exp_t  [3];
        int  n;
        bit  seen;
        exp_s = '{ref_bcd(24'd7), ref_bcd(24'd7), ref_bcd(24'd7)};
        exp_r = '{24'h0, ref_bcd(24'd500), ref_bcd(24'd500)};
        exp_t = '{24'h0, 24'h0, ref_bcd(24'd4095)};
        rst = 1'b1;
        score = 24'd7; score_req = 24'd500; timer = 12'd4095;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_done(60, n, seen);
            checks++;
            if (!seen || n != 26) begin errors++; $display("FAIL order_spacing%0d: %0d edges (seen=%0b), want 26", k, n, seen); end
            checks++;
            if (score_bcd !== exp_s[k] || score_req_bcd !== exp_r[k] || timer_bcd !== exp_t[k]) begin
                errors++;
                $display("FAIL order_result%0d: got %h/%h/%h want %h/%h/%h", k,
                         score_bcd, score_req_bcd, timer_bcd, exp_s[k], exp_r[k], exp_t[k]);
            end
        end
    endtask

    task automatic test_clamp();
        int n;
        bit seen;
        int act = 0;
        score_req = 24'd5000000;
        wait_done(60, n, seen);
        checks++;
        if (!seen || score_req_bcd !== ref_bcd(24'd999999)) begin
            errors++; $display("FAIL clamp_value: got %h (seen=%0b) want %h", score_req_bcd, seen, ref_bcd(24'd999999));
        end
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy === 1'b1 || conv_done === 1'b1) act++;
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL clamp_no_rereq: %0d active cycles, want 0", act); end
    endtask

    task automatic test_change_mid();
        int n = 0;
        bit seen;
        score = 24'd10;
        while (busy !== 1'b1 && n < 40) begin tick(); n++; end
        for (int i = 0; i < 5; i++) tick();
        score = 24'd11;
        wait_done(60, n, seen);
        checks++;
        if (!seen || score_bcd !== ref_bcd(24'd10)) begin
            errors++; $display("FAIL mid_first: got %h (seen=%0b) want %h", score_bcd, seen, ref_bcd(24'd10));
        end
        wait_done(60, n, seen);
        checks++;
        if (!seen || score_bcd !== ref_bcd(24'd11)) begin
            errors++; $display("FAIL mid_second: got %h (seen=%0b) want %h", score_bcd, seen, ref_bcd(24'd11));
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen;
        score = 24'd654321;
        while (busy !== 1'b1 && n < 40) begin tick(); n++; end
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || conv_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy: busy=%b done=%b want 0/0", busy, conv_done);
        end
        checks++;
        if (score_bcd !== 24'h0 || score_req_bcd !== 24'h0 || timer_bcd !== 24'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %h/%h/%h want all 000000", score_bcd, score_req_bcd, timer_bcd);
        end
        wait_done(60, n, seen);
        checks++;
        if (!seen || n != 26 || score_bcd !== ref_bcd(24'd654321)) begin
            errors++; $display("FAIL rstmid_reconv: got %h after %0d edges (seen=%0b) want %h after 26",
                               score_bcd, n, seen, ref_bcd(24'd654321));
        end
        for (int i = 0; i < 100; i++) tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ($urandom_range(0, 29) == 0) begin
                int ch  = int'($urandom_range(0, 2));
                int sel = int'($urandom_range(0, 3));
                logic [23:0] v;
                case (sel)
                    0:       v = 24'($urandom_range(0, 99));
                    1:       v = 24'($urandom_range(0, 999999));
                    2:       v = 24'($urandom);
                    default: v = 24'd999999 + 24'($urandom_range(0, 3));
                endcase
                if (ch == 0) score = v;
                else if (ch == 1) score_req = v;
                else timer = v[11:0];
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
            checks++;
            if (busy !== (m_left != 0)) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, busy, (m_left != 0)); end
            checks++;
            if (conv_done !== m_done) begin errors++; $display("FAIL rand_done@%0d: got %b want %b", cyc, conv_done, m_done); end
            checks++;
            if (score_bcd !== m_out[0]) begin errors++; $display("FAIL rand_score@%0d: got %h want %h", cyc, score_bcd, m_out[0]); end
            checks++;
            if (score_req_bcd !== m_out[1]) begin errors++; $display("FAIL rand_score_req@%0d: got %h want %h", cyc, score_req_bcd, m_out[1]); end
            checks++;
            if (timer_bcd !== m_out[2]) begin errors++; $display("FAIL rand_timer@%0d: got %h want %h", cyc, timer_bcd, m_out[2]); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        score = '0; score_req = '0; timer = '0;
        m_rr = 2; m_left = 0; m_ch = 0; m_snap = '0; m_done = 1'b0;
        for (int k = 0; k < 3; k++) begin m_last[k] = '0; m_out[k] = '0; end
        test_reset();
        test_single();
        test_order();
        test_clamp();
        test_change_mid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
